ysyx_22041071_ex_stage: RTL and testbench

Execute stage of the ysyx_22041071 five-stage RV64 pipeline. It consumes the registered ID/EX bundle driven by the decode stage under a valid/ready handshake. It computes the ALU result and resolves branches, and provides same-cycle forwarding (destination, write enable, result) back to decode. Results are registered into the EX/MEM bundle. Multiply and divide run on an iterative unit that back-pressures decode while busy.

---
 rtl/ysyx_22041071_pkg.sv | 32 +++
 rtl/ysyx_22041071_muldiv.sv | 104 ++++++++++
 rtl/ysyx_22041071_ex_stage.sv | 119 +++++++++++
 tb/tb_ysyx_22041071_ex_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_pkg.sv
// ysyx_22041071_pkg: shared types and helpers for the ysyx_22041071 execute stage.
package ysyx_22041071_pkg;
  localparam int XLEN = 64;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW,
    ALU_NOP
  } alu_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic            mem_w_en;
    logic            wb_sel;
    logic            reg_w_en;
    logic [4:0]      rdest;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] result;
  } exmem_t;
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  function automatic logic is_muldiv(input alu_op_e op);
    return op inside {[ALU_MUL:ALU_REMUW]};
  endfunction
  function automatic logic is_w(input alu_op_e op);
    return op inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction
endpackage

// File: rtl/ysyx_22041071_muldiv.sv
// ysyx_22041071_muldiv: iterative shift-add multiplier / restoring divider, one bit per cycle.
// Present only when YSYX_22041071_MULDIV_EN is defined; start is honoured in IDLE, ack releases DONE.
module ysyx_22041071_muldiv
  import ysyx_22041071_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ack,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_e state_q, state_d;
  alu_op_e op_q, op_d;
  logic [5:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d, dvd_q, dvd_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic w_in, s_in, mul_in, a_neg, b_neg, mul_q, ge;
  logic [XLEN-1:0] a_x, b_x, a_abs, b_abs, sub, q_val, r_val, raw;
  logic [XLEN:0] rs;
  assign w_in   = is_w(op);
  assign s_in   = op inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  assign mul_in = op inside {ALU_MUL, ALU_MULW};
  assign a_x    = w_in ? (s_in ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
  assign b_x    = w_in ? (s_in ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
  assign a_neg  = s_in & a_x[XLEN-1];
  assign b_neg  = s_in & b_x[XLEN-1];
  assign a_abs  = a_neg ? -a_x : a_x;
  assign b_abs  = b_neg ? -b_x : b_x;
  assign mul_q  = op_q inside {ALU_MUL, ALU_MULW};
  // Partial remainder is one bit wider so the shifted-in bit never overflows the compare.
  assign rs     = {acc_q, x_q[XLEN-1]};
  assign ge     = rs >= {1'b0, y_q};
  assign sub    = rs[XLEN-1:0] - y_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      MD_IDLE: if (start) begin
        state_d = MD_BUSY;
        op_d    = op;
        cnt_d   = w_in ? 6'd31 : 6'd63;
        acc_d   = '0;
        x_d     = mul_in ? a : (w_in ? {a_abs[31:0], 32'b0} : a_abs);
        y_d     = mul_in ? b : b_abs;
        dvd_d   = a_x;
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
        dz_d    = ~|b_x;
      end
      MD_BUSY: begin
        acc_d   = mul_q ? acc_q + (y_q[0] ? x_q : '0) : (ge ? sub : rs[XLEN-1:0]);
        x_d     = mul_q ? x_q << 1 : {x_q[XLEN-2:0], ge};
        y_d     = mul_q ? y_q >> 1 : y_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 6'd1;
        state_d = (cnt_q == '0) ? MD_DONE : MD_BUSY;
      end
      MD_DONE: if (ack) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      op_q    <= ALU_ADD;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end
  // Divide by zero: quotient all ones, remainder the dividend; min/-1 falls out of the magnitude path.
  assign q_val  = dz_q ? '1 : (qneg_q ? -x_q : x_q);
  assign r_val  = dz_q ? dvd_q : (rneg_q ? -acc_q : acc_q);
  assign raw    = mul_q ? acc_q : (op_q inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW} ? r_val : q_val);
  assign result = is_w(op_q) ? sext32(raw[31:0]) : raw;
  assign done   = state_q == MD_DONE;
endmodule

// File: rtl/ysyx_22041071_ex_stage.sv
// ysyx_22041071_ex_stage: RV64 execute stage with ALU, branch resolve, forwarding and EX/MEM register.
// Define YSYX_22041071_MULDIV_EN to build the iterative multiply/divide unit.
module ysyx_22041071_ex_stage
  import ysyx_22041071_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     ins_in,
  input  alu_op_e         alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] rt_data_in,
  input  logic [11:0]     bimm,
  input  logic            brch,
  input  logic            mem_w_en,
  input  logic            wb_sel,
  input  logic            reg_w_en,
  input  logic [4:0]      rdest_in,
  output logic            fwd_reg_w_en,
  output logic [4:0]      fwd_rdest,
  output logic [XLEN-1:0] fwd_result,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  input  logic            ready_in,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     ins_out,
  output logic            mem_w_en_out,
  output logic            wb_sel_out,
  output logic            reg_w_en_out,
  output logic [4:0]      rdest_out,
  output logic [XLEN-1:0] rt_data_out,
  output logic [XLEN-1:0] result_out
);
  logic [XLEN-1:0] result, md_result;
  logic cmp, lt, ltu, result_ok, fire;
  exmem_t em_q, em_d;
`ifdef YSYX_22041071_MULDIV_EN
  logic is_md, md_done;
  assign is_md = is_muldiv(alu_ctrl);
  ysyx_22041071_muldiv u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (valid_in & is_md),
    .ack    (fire),
    .op     (alu_ctrl),
    .a      (src_a),
    .b      (src_b),
    .done   (md_done),
    .result (md_result)
  );
  assign result_ok = ~is_md | md_done;
`else
  assign md_result = '0;
  assign result_ok = 1'b1;
`endif
  assign ready_out = result_ok & ready_in;
  assign fire      = valid_in & ready_out;
  assign lt        = $signed(src_a) < $signed(src_b);
  assign ltu       = src_a < src_b;
  always_comb begin
    result = '0;
    cmp    = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_SLL:  result = src_a << src_b[5:0];
      ALU_SLT:  result = {63'b0, lt};
      ALU_SLTU: result = {63'b0, ltu};
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SRL:  result = src_a >> src_b[5:0];
      ALU_SRA:  result = $signed(src_a) >>> src_b[5:0];
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_ADDW: result = sext32(src_a[31:0] + src_b[31:0]);
      ALU_SUBW: result = sext32(src_a[31:0] - src_b[31:0]);
      ALU_SLLW: result = sext32(src_a[31:0] << src_b[4:0]);
      ALU_SRLW: result = sext32(src_a[31:0] >> src_b[4:0]);
      ALU_SRAW: result = sext32($signed(src_a[31:0]) >>> src_b[4:0]);
      ALU_BEQ:  cmp = src_a == src_b;
      ALU_BNE:  cmp = src_a != src_b;
      ALU_BLT:  cmp = lt;
      ALU_BGE:  cmp = ~lt;
      ALU_BLTU: cmp = ltu;
      ALU_BGEU: cmp = ~ltu;
      ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: result = md_result;
      default:  result = '0;
    endcase
    result[0] = result[0] | cmp;
  end
  assign fwd_reg_w_en = valid_in & reg_w_en & result_ok;
  assign fwd_rdest    = rdest_in;
  assign fwd_result   = result;
  assign br_taken     = fire & brch & cmp;
  assign br_target    = pc_in + {{51{bimm[11]}}, bimm, 1'b0};
  always_comb begin
    em_d = em_q;
    if (fire) em_d = '{valid: 1'b1, pc: pc_in, ins: ins_in, mem_w_en: mem_w_en, wb_sel: wb_sel,
                       reg_w_en: reg_w_en, rdest: rdest_in, rt_data: rt_data_in, result: result};
    else if (ready_in) em_d.valid = 1'b0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) em_q <= '0;
    else em_q <= em_d;
  end
  assign valid_out    = em_q.valid;
  assign pc_out       = em_q.pc;
  assign ins_out      = em_q.ins;
  assign mem_w_en_out = em_q.mem_w_en;
  assign wb_sel_out   = em_q.wb_sel;
  assign reg_w_en_out = em_q.reg_w_en;
  assign rdest_out    = em_q.rdest;
  assign rt_data_out  = em_q.rt_data;
  assign result_out   = em_q.result;
endmodule

// File: tb/tb_ysyx_22041071_ex_stage.sv
// tb_ysyx_22041071_ex_stage: directed self-checking bench for the execute stage.
module tb_ysyx_22041071_ex_stage;
  import ysyx_22041071_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic valid_in = 1'b0, ready_out, brch = 1'b0, mem_w_en = 1'b0, wb_sel = 1'b0, reg_w_en = 1'b0;
  logic [63:0] pc_in = '0, src_a = '0, src_b = '0, rt_data_in = '0;
  logic [31:0] ins_in = '0;
  alu_op_e alu_ctrl = ALU_ADD;
  logic [11:0] bimm = '0;
  logic [4:0] rdest_in = '0;
  logic fwd_reg_w_en, br_taken, ready_in = 1'b1;
  logic [4:0] fwd_rdest, rdest_out;
  logic [63:0] fwd_result, br_target, pc_out, rt_data_out, result_out;
  logic valid_out, mem_w_en_out, wb_sel_out, reg_w_en_out;
  logic [31:0] ins_out;
  int n_cmp = 0, n_fail = 0;
  typedef struct {alu_op_e op; logic [63:0] a; logic [63:0] b; logic [63:0] e; int lat;} vec_t;

  ysyx_22041071_ex_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .pc_in(pc_in),
    .ins_in(ins_in), .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .rt_data_in(rt_data_in),
    .bimm(bimm), .brch(brch), .mem_w_en(mem_w_en), .wb_sel(wb_sel), .reg_w_en(reg_w_en),
    .rdest_in(rdest_in), .fwd_reg_w_en(fwd_reg_w_en), .fwd_rdest(fwd_rdest), .fwd_result(fwd_result),
    .br_taken(br_taken), .br_target(br_target), .ready_in(ready_in), .valid_out(valid_out),
    .pc_out(pc_out), .ins_out(ins_out), .mem_w_en_out(mem_w_en_out), .wb_sel_out(wb_sel_out),
    .reg_w_en_out(reg_w_en_out), .rdest_out(rdest_out), .rt_data_out(rt_data_out),
    .result_out(result_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input alu_op_e op, input logic [63:0] a, input logic [63:0] b);
    alu_ctrl = op; src_a = a; src_b = b; valid_in = 1'b1; reg_w_en = 1'b1; brch = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_cmp++; if (result_out !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_out); end
    n_cmp++; if (pc_out !== '0 || rdest_out !== '0 || ins_out !== '0) begin n_fail++; $display("FAIL reset_bundle got pc=%h rd=%h ins=%h want 0", pc_out, rdest_out, ins_out); end
    reset = 1'b1;
  endtask

  task automatic test_add;
    @(negedge clk);
    drive(ALU_ADD, 64'd5, -64'sd7); rdest_in = 5'd3; pc_in = 64'h100; ins_in = 32'h0000_0033; rt_data_in = 64'hABCD;
    #1;
    n_cmp++; if (fwd_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL add_fwd got %h want fffffffffffffffe", fwd_result); end
    n_cmp++; if (fwd_reg_w_en !== 1'b1 || fwd_rdest !== 5'd3 || ready_out !== 1'b1) begin n_fail++; $display("FAIL add_fwd_ctl got en=%b rd=%0d rdy=%b want 1/3/1", fwd_reg_w_en, fwd_rdest, ready_out); end
    @(posedge clk); #1;
    n_cmp++; if (result_out !== 64'hFFFF_FFFF_FFFF_FFFE || valid_out !== 1'b1) begin n_fail++; $display("FAIL add_reg got %h v=%b want fffffffffffffffe v=1", result_out, valid_out); end
    n_cmp++; if (pc_out !== 64'h100 || rdest_out !== 5'd3 || ins_out !== 32'h33 || rt_data_out !== 64'hABCD) begin n_fail++; $display("FAIL add_bundle got pc=%h rd=%0d ins=%h rt=%h", pc_out, rdest_out, ins_out, rt_data_out); end
    valid_in = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", valid_out); end
  endtask

  task automatic test_branch;
    @(negedge clk);
    drive(ALU_BLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); brch = 1'b1; reg_w_en = 1'b0; pc_in = 64'h8000_0000; bimm = 12'hFFE;
    #1;
    n_cmp++; if (br_taken !== 1'b1) begin n_fail++; $display("FAIL blt_taken got %b want 1", br_taken); end
    n_cmp++; if (br_target !== 64'h7FFF_FFFC) begin n_fail++; $display("FAIL blt_target got %h want 7ffffffc", br_target); end
    alu_ctrl = ALU_BLTU; #1;
    n_cmp++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL bltu_taken got %b want 0", br_taken); end
    alu_ctrl = ALU_BGE; bimm = 12'h010; #1;
    n_cmp++; if (br_taken !== 1'b0 || br_target !== 64'h8000_0020) begin n_fail++; $display("FAIL bge got t=%b tgt=%h want 0 80000020", br_taken, br_target); end
    alu_ctrl = ALU_BEQ; src_b = src_a; valid_in = 1'b0; #1;
    n_cmp++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL beq_novalid got %b want 0", br_taken); end
    valid_in = 1'b1; #1;
    n_cmp++; if (br_taken !== 1'b1 || fwd_result !== 64'd1) begin n_fail++; $display("FAIL beq got t=%b r=%h want 1 1", br_taken, fwd_result); end
    brch = 1'b0; #1;
    n_cmp++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL beq_nobrch got %b want 0", br_taken); end
    valid_in = 1'b0; bimm = '0;
  endtask

  task automatic test_alu;
    vec_t v[15] = '{
      '{ALU_SUB,  64'd10, 64'd3, 64'd7, 0},
      '{ALU_SLL,  64'd1, 64'd65, 64'd2, 0},
      '{ALU_SRA,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 0},
      '{ALU_SRL,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 0},
      '{ALU_SRAW, 64'h0000_0000_8000_0000, 64'h24, 64'hFFFF_FFFF_F800_0000, 0},
      '{ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 0},
      '{ALU_SLLW, 64'd1, 64'd63, 64'hFFFF_FFFF_8000_0000, 0},
      '{ALU_SUBW, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0},
      '{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0},
      '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0},
      '{ALU_XOR,  64'hF0, 64'hFF, 64'h0F, 0},
      '{ALU_OR,   64'hF0, 64'h0F, 64'hFF, 0},
      '{ALU_AND,  64'hF0, 64'h3C, 64'h30, 0},
      '{ALU_BGEU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0},
      '{ALU_NOP,  64'd5, 64'd5, 64'd0, 0}
    };
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].op, v[i].a, v[i].b);
      #1;
      n_cmp++; if (fwd_result !== v[i].e) begin n_fail++; $display("FAIL alu_%s got %h want %h", v[i].op.name(), fwd_result, v[i].e); end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic test_addw_stall;
    logic [63:0] held;
    @(negedge clk);
    drive(ALU_ADDW, 64'h7FFF_FFFF, 64'd1); rdest_in = 5'd9; ready_in = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (result_out !== 64'hFFFF_FFFF_8000_0000 || valid_out !== 1'b1) begin n_fail++; $display("FAIL addw got %h v=%b want ffffffff80000000 v=1", result_out, valid_out); end
    held = 64'hFFFF_FFFF_8000_0000;
    ready_in = 1'b0; drive(ALU_SUB, 64'd50, 64'd8); rdest_in = 5'd12;
    repeat (3) begin
      #1;
      n_cmp++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", ready_out); end
      @(posedge clk); #1;
      n_cmp++; if (result_out !== held || valid_out !== 1'b1 || rdest_out !== 5'd9) begin n_fail++; $display("FAIL stall_hold got %h v=%b rd=%0d want %h v=1 rd=9", result_out, valid_out, rdest_out, held); end
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (result_out !== 64'd42 || rdest_out !== 5'd12) begin n_fail++; $display("FAIL stall_release got %h rd=%0d want 2a rd=12", result_out, rdest_out); end
    valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef YSYX_22041071_MULDIV_EN
  task automatic run_md(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                        output int low, output logic busy_fwd, output logic [63:0] res);
    @(negedge clk);
    drive(op, a, b); ready_in = 1'b1;
    low = 0;
    #1 busy_fwd = fwd_reg_w_en;
    while (!ready_out && low < 200) begin
      low++;
      @(negedge clk); #1;
    end
    @(posedge clk); #1 res = result_out;
    valid_in = 1'b0;
  endtask

  task automatic test_muldiv;
    int low;
    logic bf;
    logic [63:0] r;
    vec_t v[13] = '{
      '{ALU_DIV,   64'd100, 64'd7, 64'd14, 65},
      '{ALU_REM,   64'd100, 64'd7, 64'd2, 65},
      '{ALU_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65},
      '{ALU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65},
      '{ALU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65},
      '{ALU_DIV,   -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65},
      '{ALU_REMU,  64'd100, 64'd0, 64'd100, 65},
      '{ALU_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65},
      '{ALU_MULW,  64'h1_0000, 64'h1_0000, 64'd0, 33},
      '{ALU_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33},
      '{ALU_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33},
      '{ALU_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33},
      '{ALU_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 33}
    };
    foreach (v[i]) begin
      run_md(v[i].op, v[i].a, v[i].b, low, bf, r);
      n_cmp++; if (r !== v[i].e) begin n_fail++; $display("FAIL md_%s_%0d got %h want %h", v[i].op.name(), i, r, v[i].e); end
      n_cmp++; if (low !== v[i].lat) begin n_fail++; $display("FAIL md_%s_%0d_lat got %0d want %0d", v[i].op.name(), i, low, v[i].lat); end
      n_cmp++; if (bf !== 1'b0) begin n_fail++; $display("FAIL md_%s_%0d_fwd got %b want 0", v[i].op.name(), i, bf); end
    end
  endtask

  task automatic test_reset_mid;
    int low;
    logic bf;
    logic [63:0] r;
    @(negedge clk);
    drive(ALU_ADD, 64'd1, 64'd1); ready_in = 1'b1;
    @(negedge clk);
    drive(ALU_MUL, 64'd5, 64'd6); ready_in = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (valid_out !== 1'b1 || dut.u_md.state_q !== MD_BUSY) begin n_fail++; $display("FAIL pre_reset got v=%b st=%0d want 1 BUSY", valid_out, dut.u_md.state_q); end
    reset = 1'b0; valid_in = 1'b0; #1;
    n_cmp++; if (valid_out !== 1'b0 || result_out !== '0) begin n_fail++; $display("FAIL mid_reset got v=%b r=%h want 0", valid_out, result_out); end
    n_cmp++; if (dut.u_md.state_q !== MD_IDLE) begin n_fail++; $display("FAIL mid_reset_state got %0d want IDLE", dut.u_md.state_q); end
    @(negedge clk); reset = 1'b1; ready_in = 1'b1;
    run_md(ALU_MUL, 64'd3, 64'd4, low, bf, r);
    n_cmp++; if (r !== 64'd12 || low !== 65) begin n_fail++; $display("FAIL mul_after_reset got %h lat=%0d want c lat=65", r, low); end
  endtask
`else
  task automatic test_muldiv_off;
    @(negedge clk);
    drive(ALU_DIV, 64'd100, 64'd7); ready_in = 1'b1;
    #1;
    n_cmp++; if (ready_out !== 1'b1 || fwd_result !== '0 || fwd_reg_w_en !== 1'b1) begin n_fail++; $display("FAIL div_off got rdy=%b r=%h en=%b want 1 0 1", ready_out, fwd_result, fwd_reg_w_en); end
    @(posedge clk); #1;
    n_cmp++; if (result_out !== '0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL div_off_reg got %h v=%b want 0 v=1", result_out, valid_out); end
    @(negedge clk);
    drive(ALU_MULW, 64'd3, 64'd4); #1;
    n_cmp++; if (ready_out !== 1'b1 || fwd_result !== '0) begin n_fail++; $display("FAIL mulw_off got rdy=%b r=%h want 1 0", ready_out, fwd_result); end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(ALU_XOR, 64'd6, 64'd3); ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; ready_in = 1'b0; #1;
    n_cmp++; if (valid_out !== 1'b1 || result_out !== 64'd5) begin n_fail++; $display("FAIL pre_reset got v=%b r=%h want 1 5", valid_out, result_out); end
    reset = 1'b0; #1;
    n_cmp++; if (valid_out !== 1'b0 || result_out !== '0) begin n_fail++; $display("FAIL async_reset got v=%b r=%h want 0", valid_out, result_out); end
    @(negedge clk); reset = 1'b1; ready_in = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_branch;
    test_alu;
    test_addw_stall;
`ifdef YSYX_22041071_MULDIV_EN
    test_muldiv;
`else
    test_muldiv_off;
`endif
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
